// File: rtl/regfile_write_sched.sv
// regfile_write_sched
//   Register-file writeback scheduler. N_REQ writeback sources share two write
//   ports, reg3 (D_Bus) and reg4 (D_Addr). A round-robin scan hands out up to
//   two grants per cycle. The second grant never targets the same register as
//   the first. Granted writes are registered and appear on the ports one cycle
//   later. pend_mask lets decode stall on read-after-write hazards.
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   hold                freeze arbitration (no grants this cycle)
//   req_valid/addr/data flat per-requester request bundle, slice i = requester i
//   req_ready           combinational grant (transfer on valid & ready)
//   reg3_* / reg4_*     registered write ports
//   pend_mask           one-hot OR of addresses currently being written
//   conflict_cnt        saturating count of cycles with a collision deferral
module regfile_write_sched #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     hold,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [ADDR_W*N_REQ-1:0]  req_addr,
  input  logic [DATA_W*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     reg3_write,
  output logic [ADDR_W-1:0]        reg3_addr,
  output logic [DATA_W-1:0]        reg3_bus,
  output logic                     reg4_write,
  output logic [ADDR_W-1:0]        reg4_addr,
  output logic [DATA_W-1:0]        reg4_bus,
  output logic [2**ADDR_W-1:0]     pend_mask,
  output logic [7:0]               conflict_cnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0][ADDR_W-1:0] addr_a;
  logic [N_REQ-1:0][DATA_W-1:0] data_a;
  assign addr_a = req_addr;
  assign data_a = req_data;

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              reg3_write_q, reg3_write_d, reg4_write_q, reg4_write_d;
  logic [ADDR_W-1:0] reg3_addr_q, reg3_addr_d, reg4_addr_q, reg4_addr_d;
  logic [DATA_W-1:0] reg3_bus_q, reg3_bus_d, reg4_bus_q, reg4_bus_d;
  logic [7:0]        conflict_cnt_q, conflict_cnt_d;

  logic [N_REQ-1:0]  grant;
  logic              a_vld, b_vld, deferred;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_data, b_data;
  logic [PTR_W-1:0]  last_idx, idx;
  int                s;

  // Round-robin scan starting at rr_ptr. A requester whose address matches
  // slot A is only counted as a collision while slot B is still open. Once
  // both slots are full, any remaining requester simply waits for capacity.
  always_comb begin
    grant    = '0;
    a_vld    = 1'b0;
    b_vld    = 1'b0;
    deferred = 1'b0;
    a_addr   = '0;
    b_addr   = '0;
    a_data   = '0;
    b_data   = '0;
    last_idx = rr_ptr_q;
    idx      = '0;
    s        = 0;
    if (rst_n && !hold) begin
      for (int k = 0; k < N_REQ; k++) begin
        s = int'(rr_ptr_q) + k;
        if (s >= N_REQ) s = s - N_REQ;
        idx = PTR_W'(s);
        if (req_valid[idx]) begin
          if (!a_vld) begin
            a_vld       = 1'b1;
            a_addr      = addr_a[idx];
            a_data      = data_a[idx];
            grant[idx]  = 1'b1;
            last_idx    = idx;
          end else if (!b_vld) begin
            if (addr_a[idx] != a_addr) begin
              b_vld      = 1'b1;
              b_addr     = addr_a[idx];
              b_data     = data_a[idx];
              grant[idx] = 1'b1;
              last_idx   = idx;
            end else begin
              deferred = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (a_vld) rr_ptr_d = (last_idx == PTR_W'(N_REQ - 1)) ? '0 : last_idx + 1'b1;

    reg3_write_d = a_vld;
    reg3_addr_d  = a_vld ? a_addr : reg3_addr_q;
    reg3_bus_d   = a_vld ? a_data : reg3_bus_q;
    reg4_write_d = b_vld;
    reg4_addr_d  = b_vld ? b_addr : reg4_addr_q;
    reg4_bus_d   = b_vld ? b_data : reg4_bus_q;

    conflict_cnt_d = conflict_cnt_q;
    if (deferred && conflict_cnt_q != 8'hFF) conflict_cnt_d = conflict_cnt_q + 8'd1;
  end

  // Reset clears the output stage, so a write in flight is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q       <= '0;
      reg3_write_q   <= 1'b0;
      reg3_addr_q    <= '0;
      reg3_bus_q     <= '0;
      reg4_write_q   <= 1'b0;
      reg4_addr_q    <= '0;
      reg4_bus_q     <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      reg3_write_q   <= reg3_write_d;
      reg3_addr_q    <= reg3_addr_d;
      reg3_bus_q     <= reg3_bus_d;
      reg4_write_q   <= reg4_write_d;
      reg4_addr_q    <= reg4_addr_d;
      reg4_bus_q     <= reg4_bus_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  always_comb begin
    pend_mask = '0;
    if (reg3_write_q) pend_mask[reg3_addr_q] = 1'b1;
    if (reg4_write_q) pend_mask[reg4_addr_q] = 1'b1;
  end

  assign req_ready    = grant;
  assign reg3_write   = reg3_write_q;
  assign reg3_addr    = reg3_addr_q;
  assign reg3_bus     = reg3_bus_q;
  assign reg4_write   = reg4_write_q;
  assign reg4_addr    = reg4_addr_q;
  assign reg4_bus     = reg4_bus_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed tests for regfile_write_sched with hand-computed expectations,
// followed by a randomised soak against a per-requester sequence scoreboard.
module tb_regfile_write_sched;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            hold = 1'b0;
  logic [2:0]      vld = '0;
  logic [2:0][3:0] adr = '0;
  logic [2:0][15:0] dat = '0;
  logic [2:0]      rdy;
  logic            w3, w4;
  logic [3:0]      a3, a4;
  logic [15:0]     b3, b4, pend;
  logic [7:0]      cnt;

  int n_chk = 0;
  int n_pass = 0;

  regfile_write_sched #(.N_REQ(3), .ADDR_W(4), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .req_valid(vld), .req_addr(adr), .req_data(dat), .req_ready(rdy),
    .reg3_write(w3), .reg3_addr(a3), .reg3_bus(b3),
    .reg4_write(w4), .reg4_addr(a4), .reg4_bus(b4),
    .pend_mask(pend), .conflict_cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // soak scoreboard
  int         exp_seq[3];
  int         nxt_seq[3];
  logic [3:0] xadr[3];
  logic [2:0] xfer;

  task automatic port_chk(input logic [3:0] a, input logic [15:0] d);
    int r;
    r = int'(d[15:12]);
    if (r < 3) begin
      chk("soak_src", {31'd0, xfer[r]}, 32'd1);
      chk("soak_seq", {20'd0, d[11:0]}, exp_seq[r] & 32'hFFF);
      chk("soak_addr", {28'd0, a}, {28'd0, xadr[r]});
      exp_seq[r]++;
    end else begin
      chk("soak_src", r, 32'd0);
    end
  endtask

  initial begin
    // 1: reset with all requesters valid
    vld = 3'b111;
    adr = {4'd3, 4'd2, 4'd1};
    dat = {16'h000C, 16'h000B, 16'h000A};
    #1 chk("t1_rdy_rst", {29'd0, rdy}, 32'd0);
    tick(); tick();
    chk("t1_w3_rst", {31'd0, w3}, 32'd0);
    chk("t1_w4_rst", {31'd0, w4}, 32'd0);
    chk("t1_pend_rst", {16'd0, pend}, 32'd0);
    chk("t1_cnt_rst", {24'd0, cnt}, 32'd0);
    chk("t1_rdy_rst2", {29'd0, rdy}, 32'd0);
    rst_n = 1'b1;
    #1 chk("t1_rdy_rel", {29'd0, rdy}, 32'h3);
    tick();
    vld = 3'b100;
    chk("t1_w3", {31'd0, w3}, 32'd1);
    chk("t1_a3", {28'd0, a3}, 32'd1);
    chk("t1_b3", {16'd0, b3}, 32'h000A);
    chk("t1_a4", {28'd0, a4}, 32'd2);
    chk("t1_pend", {16'd0, pend}, 32'h0006);
    // reset drops the write sitting in the output stage
    rst_n = 1'b0;
    #1 chk("t1_rdy_rst3", {29'd0, rdy}, 32'd0);
    tick();
    chk("t1_drop_w3", {31'd0, w3}, 32'd0);
    chk("t1_drop_w4", {31'd0, w4}, 32'd0);
    chk("t1_drop_a3", {28'd0, a3}, 32'd0);
    vld = 3'b000;
    rst_n = 1'b1;

    // 2: single requester
    vld = 3'b010; adr[1] = 4'd5; dat[1] = 16'hBEEF;
    #1 chk("t2_rdy", {29'd0, rdy}, 32'h2);
    tick();
    vld = 3'b000;
    chk("t2_w3", {31'd0, w3}, 32'd1);
    chk("t2_a3", {28'd0, a3}, 32'd5);
    chk("t2_b3", {16'd0, b3}, 32'hBEEF);
    chk("t2_w4", {31'd0, w4}, 32'd0);
    chk("t2_pend", {16'd0, pend}, 32'h0020);
    tick();
    chk("t2_idle_w3", {31'd0, w3}, 32'd0);
    chk("t2_idle_a3", {28'd0, a3}, 32'd5);
    chk("t2_idle_pend", {16'd0, pend}, 32'd0);

    rst_n = 1'b0; tick(); rst_n = 1'b1;

    // 3: three requesters, distinct addresses, rr_ptr=0
    vld = 3'b111; adr = {4'd3, 4'd2, 4'd1}; dat = {16'h0033, 16'h0022, 16'h0011};
    #1 chk("t3_rdy0", {29'd0, rdy}, 32'h3);
    tick();
    vld = 3'b100;
    chk("t3_b3_0", {16'd0, b3}, 32'h0011);
    chk("t3_b4_0", {16'd0, b4}, 32'h0022);
    chk("t3_w4_0", {31'd0, w4}, 32'd1);
    #1 chk("t3_rdy1", {29'd0, rdy}, 32'h4);
    tick();
    vld = 3'b000;
    chk("t3_a3_1", {28'd0, a3}, 32'd3);
    chk("t3_b3_1", {16'd0, b3}, 32'h0033);
    chk("t3_w4_1", {31'd0, w4}, 32'd0);

    // 4: collision, rr_ptr back at 0
    vld = 3'b011; adr[0] = 4'd7; adr[1] = 4'd7; dat[0] = 16'h0070; dat[1] = 16'h0071;
    #1 chk("t4_rdy0", {29'd0, rdy}, 32'h1);
    tick();
    vld = 3'b010;
    chk("t4_cnt", {24'd0, cnt}, 32'd1);
    chk("t4_b3_0", {16'd0, b3}, 32'h0070);
    chk("t4_w4_0", {31'd0, w4}, 32'd0);
    #1 chk("t4_rdy1", {29'd0, rdy}, 32'h2);
    tick();
    vld = 3'b000;
    chk("t4_b3_1", {16'd0, b3}, 32'h0071);
    chk("t4_cnt1", {24'd0, cnt}, 32'd1);

    // 5: hold mid-stream; rr_ptr is 2 here
    vld = 3'b111; adr = {4'd3, 4'd2, 4'd1}; dat = {16'h00C5, 16'h00B5, 16'h00A5};
    #1 chk("t5_rdy0", {29'd0, rdy}, 32'h5);
    tick();
    chk("t5_b3_0", {16'd0, b3}, 32'h00C5);
    chk("t5_b4_0", {16'd0, b4}, 32'h00A5);
    // req1 still waiting on addr 2; req0 re-requests addr 2 -> collision once released
    vld = 3'b011; adr[0] = 4'd2; dat[0] = 16'h0090;
    hold = 1'b1;
    #1 chk("t5_rdy_hold", {29'd0, rdy}, 32'd0);
    tick();
    chk("t5_w3_hold", {31'd0, w3}, 32'd0);
    chk("t5_w4_hold", {31'd0, w4}, 32'd0);
    chk("t5_pend_hold", {16'd0, pend}, 32'd0);
    tick();
    chk("t5_cnt_hold", {24'd0, cnt}, 32'd1);
    hold = 1'b0;
    #1 chk("t5_rdy_rel", {29'd0, rdy}, 32'h2);
    tick();
    vld = 3'b001;
    chk("t5_b3_rel", {16'd0, b3}, 32'h00B5);
    chk("t5_cnt_rel", {24'd0, cnt}, 32'd2);
    #1 chk("t5_rdy_rel2", {29'd0, rdy}, 32'h1);
    tick();
    vld = 3'b000;
    chk("t5_b3_rel2", {16'd0, b3}, 32'h0090);

    // 6: sustained collision, counter saturation
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    vld = 3'b011; adr[0] = 4'd9; adr[1] = 4'd9; dat[0] = 16'h1111; dat[1] = 16'h2222;
    for (int i = 0; i < 100; i++) tick();
    chk("t6_cnt100", {24'd0, cnt}, 32'd100);
    for (int i = 0; i < 200; i++) tick();
    chk("t6_cnt_sat", {24'd0, cnt}, 32'd255);
    tick();
    chk("t6_cnt_sat2", {24'd0, cnt}, 32'd255);
    vld = 3'b000;

    // random soak
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin exp_seq[i] = 0; nxt_seq[i] = 0; xadr[i] = '0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      hold = ($urandom_range(7) == 0);
      for (int i = 0; i < 3; i++) begin
        if (!vld[i] && $urandom_range(1) == 1) begin
          vld[i] = 1'b1;
          adr[i] = 4'($urandom_range(3));
          dat[i] = {4'(i), 12'(nxt_seq[i])};
        end
      end
      #1;
      xfer = vld & rdy;
      for (int i = 0; i < 3; i++) if (xfer[i]) xadr[i] = adr[i];
      tick();
      chk("soak_nwr", 32'(w3) + 32'(w4), 32'(xfer[0]) + 32'(xfer[1]) + 32'(xfer[2]));
      if (w3 && w4) chk("soak_dual", {31'd0, a3 == a4}, 32'd0);
      if (w3) port_chk(a3, b3);
      if (w4) port_chk(a4, b4);
      for (int i = 0; i < 3; i++) if (xfer[i]) begin vld[i] = 1'b0; nxt_seq[i]++; end
    end
    for (int i = 0; i < 3; i++) chk("soak_total", exp_seq[i], nxt_seq[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
